// File: rtl/t09_dir_pkg.sv
// Shared encodings for the snake direction controller: direction codes, button
// one-hot patterns and the reversal/mapping helpers used by every lane.
package t09_dir_pkg;

    typedef enum logic [2:0] {
        DirUp    = 3'd0,
        DirDown  = 3'd1,
        DirLeft  = 3'd2,
        DirRight = 3'd3,
        DirStop  = 3'd4
    } dir_t;

    localparam logic [3:0] BtnUp    = 4'b0001;
    localparam logic [3:0] BtnDown  = 4'b0010;
    localparam logic [3:0] BtnRight = 4'b0100;
    localparam logic [3:0] BtnLeft  = 4'b1000;

    function automatic dir_t opposite(input dir_t d);
        dir_t r;
        case (d)
            DirUp:    r = DirDown;
            DirDown:  r = DirUp;
            DirLeft:  r = DirRight;
            DirRight: r = DirLeft;
            default:  r = DirStop;
        endcase
        return r;
    endfunction

    // Non-one-hot patterns map to STOP; callers gate on one-hotness separately.
    function automatic dir_t btn2dir(input logic [3:0] b);
        dir_t r;
        case (b)
            BtnUp:    r = DirUp;
            BtnDown:  r = DirDown;
            BtnRight: r = DirRight;
            BtnLeft:  r = DirLeft;
            default:  r = DirStop;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/t09_dir_lane.sv
// One player lane: button edge detect, reversal/duplicate filter, turn queue and
// committed direction. Overflow flag present only when T09_DIR_OVF_EN is defined.
module t09_dir_lane
    import t09_dir_pkg::*;
#(
    parameter int unsigned QDEPTH = 4
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [3:0]                    btn,
    input  logic                          sync,
    input  logic                          pulse,
    output logic [2:0]                    direction,
    output logic [$clog2(QDEPTH+1)-1:0]   q_count
`ifdef T09_DIR_OVF_EN
    ,
    output logic                          overflow
`endif
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned PW = $clog2(QDEPTH);

    logic [3:0]    hist_q, hist_d;
    dir_t          dir_q, dir_d;
    dir_t          tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    dir_t          mem_q [QDEPTH];

    dir_t cand, tail;
    logic cand_vld, legal, full, pop, push;

    always_comb begin
        hist_d   = btn;
        cand     = btn2dir(btn);
        cand_vld = $onehot(btn) && (btn != hist_q);
        // With an empty queue the next turn is judged against the committed direction.
        tail     = (cnt_q != '0) ? tail_q : dir_q;
        legal    = (tail == DirStop) || ((cand != tail) && (cand != opposite(tail)));
        full     = (cnt_q == CW'(QDEPTH));
        pop      = pulse && (cnt_q != '0) && !sync;
        push     = cand_vld && legal && (!full || pop) && !sync;

        dir_d  = dir_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        if (sync) begin
            dir_d  = DirStop;
            tail_d = DirStop;
            cnt_d  = '0;
            wr_d   = '0;
            rd_d   = '0;
        end else begin
            if (pop) begin
                dir_d = mem_q[rd_q];
                rd_d  = rd_q + PW'(1);
            end
            if (push) begin
                tail_d = cand;
                wr_d   = wr_q + PW'(1);
            end
            if (push && !pop) cnt_d = cnt_q + CW'(1);
            else if (pop && !push) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hist_q <= '0;
            dir_q  <= DirStop;
            tail_q <= DirStop;
            cnt_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
        end else begin
            hist_q <= hist_d;
            dir_q  <= dir_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
        end
    end

    // Queue storage needs no reset: entries are only read behind a nonzero count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= cand;
    end

    assign direction = dir_q;
    assign q_count   = cnt_q;

`ifdef T09_DIR_OVF_EN
    logic ovf_q, ovf_d;
    logic drop;

    always_comb begin
        drop  = cand_vld && legal && full && !pop;
        ovf_d = sync ? 1'b0 : (ovf_q | drop);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign overflow = ovf_q;
`endif

endmodule

// File: rtl/t09_fsm_direction_q.sv
// Multi-player snake direction controller: NPLAYERS independent lanes sharing
// sync/pulse. Define T09_DIR_OVF_EN to add the sticky per-lane overflow output.
module t09_fsm_direction_q
    import t09_dir_pkg::*;
#(
    parameter int unsigned NPLAYERS = 2,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic                                    clk,
    input  logic                                    nrst,
    input  logic [4*NPLAYERS-1:0]                   direction_a,
    input  logic                                    sync,
    input  logic                                    pulse,
    output logic [3*NPLAYERS-1:0]                   direction,
    output logic [$clog2(QDEPTH+1)*NPLAYERS-1:0]    q_count
`ifdef T09_DIR_OVF_EN
    ,
    output logic [NPLAYERS-1:0]                     overflow
`endif
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);

    for (genvar p = 0; p < NPLAYERS; p++) begin : g_lane
        t09_dir_lane #(
            .QDEPTH (QDEPTH)
        ) u_lane (
            .clk       (clk),
            .nrst      (nrst),
            .btn       (direction_a[4*p +: 4]),
            .sync      (sync),
            .pulse     (pulse),
            .direction (direction[3*p +: 3]),
            .q_count   (q_count[CW*p +: CW])
`ifdef T09_DIR_OVF_EN
            ,
            .overflow  (overflow[p])
`endif
        );
    end

endmodule

// File: tb/tb_t09_fsm_direction_q.sv
// Bench for t09_fsm_direction_q: queue-based lane model checked every cycle,
// plus hand-computed literal checks along the directed scenarios.
module tb_t09_fsm_direction_q;

    localparam int NP = 2;
    localparam int QD = 4;
    localparam int CW = $clog2(QD + 1);

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic [4*NP-1:0]   direction_a = '0;
    logic              sync = 1'b0;
    logic              pulse = 1'b0;
    logic [3*NP-1:0]   direction;
    logic [CW*NP-1:0]  q_count;
`ifdef T09_DIR_OVF_EN
    logic [NP-1:0]     overflow;
`endif

    t09_fsm_direction_q #(
        .NPLAYERS (NP),
        .QDEPTH   (QD)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .direction_a (direction_a),
        .sync        (sync),
        .pulse       (pulse),
        .direction   (direction),
        .q_count     (q_count)
`ifdef T09_DIR_OVF_EN
        ,
        .overflow    (overflow)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Model state: per-lane queue of directions, committed direction, button history.
    int         mq [NP][$];
    int         mdir [NP];
    logic [3:0] mprev [NP];
    bit         movf [NP];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dut_dir(input int p);
        return int'(direction[3*p +: 3]);
    endfunction

    function automatic int dut_cnt(input int p);
        return int'(q_count[CW*p +: CW]);
    endfunction

    function automatic int btn_dir(input logic [3:0] b);
        case (b)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 3;
            4'b1000: return 2;
            default: return 4;
        endcase
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            mq[p].delete();
            mdir[p]  = 4;
            mprev[p] = 4'b0000;
            movf[p]  = 1'b0;
        end
    endtask

    task automatic model_step(input logic [4*NP-1:0] b, input bit s, input bit pl);
        for (int p = 0; p < NP; p++) begin
            logic [3:0] bl;
            bit pressed, fire;
            int c, tail;
            bl      = b[4*p +: 4];
            pressed = ($countones(bl) == 1) && (bl != mprev[p]);
            c       = btn_dir(bl);
            mprev[p] = bl;
            if (s) begin
                mq[p].delete();
                mdir[p] = 4;
                movf[p] = 1'b0;
            end else begin
                tail = (mq[p].size() > 0) ? mq[p][$] : mdir[p];
                fire = pl && (mq[p].size() > 0);
                // Opposite pairs differ only in bit 0: UP0/DOWN1, LEFT2/RIGHT3.
                if (pressed && (tail == 4 || (c != tail && c != (tail ^ 1)))) begin
                    if (mq[p].size() < QD || fire) mq[p].push_back(c);
                    else movf[p] = 1'b1;
                end
                if (fire) mdir[p] = mq[p].pop_front();
            end
        end
    endtask

    always @(negedge clk) begin
        if (nrst) begin
            for (int p = 0; p < NP; p++) begin
                check($sformatf("model dir%0d", p), dut_dir(p), mdir[p]);
                check($sformatf("model cnt%0d", p), dut_cnt(p), mq[p].size());
`ifdef T09_DIR_OVF_EN
                check($sformatf("model ovf%0d", p), int'(overflow[p]), int'(movf[p]));
`endif
            end
        end
    end

    task automatic step(input logic [4*NP-1:0] b, input bit s, input bit pl);
        direction_a = b;
        sync        = s;
        pulse       = pl;
        @(posedge clk);
        model_step(b, s, pl);
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("reset dir0", dut_dir(0), 4);
        check("reset cnt0", dut_cnt(0), 0);
        #1 nrst = 1'b1;
        @(negedge clk);

        // 1: pulse with nothing queued
        step(8'h00, 0, 1);
        check("t1 dir0", dut_dir(0), 4);
        check("t1 dir1", dut_dir(1), 4);
        check("t1 cnt0", dut_cnt(0), 0);

        // 2: UP then RIGHT on lane 0, two pulses
        step(8'h01, 0, 0);
        step(8'h00, 0, 0);
        step(8'h04, 0, 0);
        step(8'h00, 0, 0);
        check("t2 cnt0 queued", dut_cnt(0), 2);
        step(8'h00, 0, 1);
        check("t2 dir0 first", dut_dir(0), 0);
        check("t2 cnt0 after 1", dut_cnt(0), 1);
        step(8'h00, 0, 1);
        check("t2 dir0 second", dut_dir(0), 3);
        check("t2 cnt0 after 2", dut_cnt(0), 0);
        check("t2 dir1", dut_dir(1), 4);

        // 3: commit UP, then reversal and duplicate are rejected
        step(8'h01, 0, 0);
        step(8'h00, 0, 1);
        check("t3 dir0 up", dut_dir(0), 0);
        step(8'h02, 0, 0);
        check("t3 reverse rejected", dut_cnt(0), 0);
        step(8'h00, 0, 0);
        step(8'h01, 0, 0);
        check("t3 duplicate rejected", dut_cnt(0), 0);

        // 4: fill queue, drop on full, pulse frees a slot for a same-cycle press
        step(8'h00, 1, 0);
        step(8'h01, 0, 0);
        step(8'h00, 0, 0);
        step(8'h04, 0, 0);
        step(8'h00, 0, 0);
        step(8'h02, 0, 0);
        step(8'h00, 0, 0);
        step(8'h08, 0, 0);
        step(8'h00, 0, 0);
        check("t4 full", dut_cnt(0), 4);
        step(8'h01, 0, 0);
        check("t4 drop keeps cnt", dut_cnt(0), 4);
`ifdef T09_DIR_OVF_EN
        check("t4 overflow set", int'(overflow[0]), 1);
`endif
        step(8'h00, 0, 0);
        step(8'h02, 0, 1);
        check("t4 push+pop cnt", dut_cnt(0), 4);
        check("t4 push+pop dir", dut_dir(0), 0);

        // 5: held button gives one entry; press with pulse on empty queue waits
        step(8'h00, 1, 0);
        step(8'h21, 0, 1);
        check("t5 not committed", dut_dir(0), 4);
        for (int i = 0; i < 9; i++) step(8'h21, 0, 0);
        check("t5 hold cnt0", dut_cnt(0), 1);
        check("t5 hold cnt1", dut_cnt(1), 1);
        step(8'h23, 0, 0);
        check("t5 multi-bit ignored", dut_cnt(0), 1);

        // 6: sync beats a same-cycle press and pulse
        step(8'h00, 0, 0);
        step(8'h04, 0, 0);
        step(8'h00, 0, 0);
        step(8'h02, 0, 0);
        check("t6 three queued", dut_cnt(0), 3);
        step(8'h08, 1, 1);
        check("t6 sync dir0", dut_dir(0), 4);
        check("t6 sync cnt0", dut_cnt(0), 0);
        check("t6 sync cnt1", dut_cnt(1), 0);
`ifdef T09_DIR_OVF_EN
        check("t6 sync ovf0", int'(overflow[0]), 0);
`endif
        step(8'h00, 0, 1);
        check("t6 stays stop", dut_dir(0), 4);

        // 7: asynchronous reset between edges
        step(8'h04, 0, 0);
        step(8'h20, 0, 0);
        step(8'h00, 0, 1);
        check("t7 dir0 before", dut_dir(0), 3);
        check("t7 dir1 before", dut_dir(1), 1);
        step(8'h01, 0, 0);
        #2 nrst = 1'b0;
        model_reset();
        #1;
        check("t7 async dir0", dut_dir(0), 4);
        check("t7 async dir1", dut_dir(1), 1 + 3);
        check("t7 async cnt0", dut_cnt(0), 0);
        direction_a = '0;
        @(negedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        step(8'h00, 0, 0);
        step(8'h00, 0, 1);
        check("t7 no phantom cnt", dut_cnt(0), 0);
        check("t7 no phantom dir", dut_dir(0), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
